alu_arbiter: RTL and testbench

// - Shares one combinational alu instance between NUM_REQ requesters (e.g. execute stage, address-gen, debug port).
// - Round-robin grant, valid/ready on each request and on the single response channel.
// - One operation outstanding at a time; operands and results are registered.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu.sv | 45 ++++
 rtl/alu_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the alu and the alu_arbiter that fronts it.
// Control and FSM constants are plain localparams for legacy tools.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int DATA_W = 32;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit alu: add, sub, and, or with carry/zero/negative.
// Control[2] is accepted for encoding compatibility but has no effect.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Control,
    output logic [31:0] Result,
    output logic        Carry,
    output logic        Zero,
    output logic        Negative
);

    logic [32:0] sum;
    logic        unused_ctrl;

    assign unused_ctrl = Control[2];

    always_comb begin
        sum    = '0;
        Result = '0;
        Carry  = 1'b0;
        unique case (Control[1:0])
            ALU_ADD[1:0]: begin
                sum    = {1'b0, A} + {1'b0, B};
                Result = sum[31:0];
                Carry  = sum[32];
            end
            ALU_SUB[1:0]: begin
                // Subtract as A + ~B + 1 so Carry means "no borrow".
                sum    = {1'b0, A} + {1'b0, ~B} + 33'd1;
                Result = sum[31:0];
                Carry  = sum[32];
            end
            ALU_AND[1:0]: Result = A & B;
            ALU_OR[1:0]:  Result = A | B;
            default:      Result = '0;
        endcase
    end

    assign Zero     = (Result == 32'd0);
    assign Negative = Result[31];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one alu among NUM_REQ requesters.
// One op in flight: IDLE accepts, EXEC computes, RESP holds the answer.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int SRC_W   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic [3*NUM_REQ-1:0]  req_ctrl,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_result,
    output logic                  rsp_carry,
    output logic                  rsp_zero,
    output logic                  rsp_negative,
    output logic [SRC_W-1:0]      rsp_src,
    output logic                  busy
);

    logic [1:0]       state_q, state_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [SRC_W-1:0] src_q, src_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_neg_q, rsp_neg_d;
    logic [SRC_W-1:0] rsp_src_q, rsp_src_d;

    logic             idle;
    logic             gnt_found;
    logic [SRC_W-1:0] gnt_idx;
    logic [SRC_W:0]   scan;
    logic [31:0]      a_sel;
    logic [31:0]      b_sel;
    logic [2:0]       ctrl_sel;
    logic             hs;

    logic [31:0]      alu_res;
    logic             alu_carry;
    logic             alu_zero;
    logic             alu_neg;

    assign idle = (state_q == S_IDLE);

    // Scan from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
            if (scan >= (SRC_W+1)'(NUM_REQ))
                scan = scan - (SRC_W+1)'(NUM_REQ);
            if (!gnt_found && req_valid[scan[SRC_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        ctrl_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == SRC_W'(i)) begin
                req_ready[i] = idle && gnt_found;
                a_sel        = req_a[32*i +: 32];
                b_sel        = req_b[32*i +: 32];
                ctrl_sel     = req_ctrl[3*i +: 3];
            end
        end
    end

    assign hs = idle && gnt_found;

    alu u_alu (
        .A        (a_q),
        .B        (b_q),
        .Control  (ctrl_q),
        .Result   (alu_res),
        .Carry    (alu_carry),
        .Zero     (alu_zero),
        .Negative (alu_neg)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        a_d          = a_q;
        b_d          = b_q;
        ctrl_d       = ctrl_q;
        src_d        = src_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_neg_d    = rsp_neg_q;
        rsp_src_d    = rsp_src_q;
        unique case (state_q)
            S_IDLE: begin
                if (hs) begin
                    a_d      = a_sel;
                    b_d      = b_sel;
                    ctrl_d   = ctrl_sel;
                    src_d    = gnt_idx;
                    rr_ptr_d = (gnt_idx == SRC_W'(NUM_REQ-1)) ?
                               '0 : gnt_idx + 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_result_d = alu_res;
                rsp_carry_d  = alu_carry;
                rsp_zero_d   = alu_zero;
                rsp_neg_d    = alu_neg;
                rsp_src_d    = src_q;
                rsp_valid_d  = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            ctrl_q       <= '0;
            src_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_neg_q    <= 1'b0;
            rsp_src_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ctrl_q       <= ctrl_d;
            src_q        <= src_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_neg_q    <= rsp_neg_d;
            rsp_src_q    <= rsp_src_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_negative = rsp_neg_q;
    assign rsp_src      = rsp_src_q;
    assign busy         = !idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus reset/stall sequences.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [5:0]  req_ctrl;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        rsp_negative;
    logic [0:0]  rsp_src;
    logic        busy;

    int total;
    int bad;

    alu_arbiter #(.NUM_REQ(2), .SRC_W(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ctrl     (req_ctrl),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_zero     (rsp_zero),
        .rsp_negative (rsp_negative),
        .rsp_src      (rsp_src),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [2:0]  c0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [2:0]  c1;
        logic [1:0]  gnt;
        logic [31:0] res;
        logic        cy;
        logic        z;
        logic        n;
        logic        src;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t t);
        req_valid = t.v;
        req_a     = {t.a1, t.a0};
        req_b     = {t.b1, t.b0};
        req_ctrl  = {t.c1, t.c0};
    endtask

    task automatic run_vec(input int i);
        vec_t t;
        t = vecs[i];
        drive(t);
        #1;
        chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(t.gnt));
        tick();
        chk($sformatf("v%0d exec busy", i), 32'(busy), 32'd1);
        chk($sformatf("v%0d exec ready", i), 32'(req_ready), 32'd0);
        chk($sformatf("v%0d exec rsp_valid", i), 32'(rsp_valid), 32'd0);
        req_valid = 2'b00;
        tick();
        chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
        chk($sformatf("v%0d result", i), rsp_result, t.res);
        chk($sformatf("v%0d carry", i), 32'(rsp_carry), 32'(t.cy));
        chk($sformatf("v%0d zero", i), 32'(rsp_zero), 32'(t.z));
        chk($sformatf("v%0d neg", i), 32'(rsp_negative), 32'(t.n));
        chk($sformatf("v%0d src", i), 32'(rsp_src), 32'(t.src));
        tick();
        chk($sformatf("v%0d done valid", i), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d done busy", i), 32'(busy), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;

        // v, a0, b0, c0, a1, b1, c1, gnt, res, cy, z, n, src
        vecs[0]  = '{2'b10, 0, 0, 3'b000, 5, 3, 3'b001,
                     2'b10, 32'd2, 1, 0, 0, 1};
        vecs[1]  = '{2'b01, 7, 7, 3'b001, 0, 0, 3'b000,
                     2'b01, 32'd0, 1, 1, 0, 0};
        vecs[2]  = '{2'b01, 0, 1, 3'b001, 0, 0, 3'b000,
                     2'b01, 32'hFFFF_FFFF, 0, 0, 1, 0};
        vecs[3]  = '{2'b01, 32'hF0F0_0000, 32'h0FF0_FFFF, 3'b010,
                     0, 0, 3'b000,
                     2'b01, 32'h00F0_0000, 0, 0, 0, 0};
        vecs[4]  = '{2'b10, 0, 0, 3'b000,
                     32'hF0F0_0000, 32'h0FF0_FFFF, 3'b011,
                     2'b10, 32'hFFF0_FFFF, 0, 0, 1, 1};
        vecs[5]  = '{2'b01, 32'hFFFF_FFFF, 1, 3'b000, 0, 0, 3'b000,
                     2'b01, 32'd0, 1, 1, 0, 0};
        vecs[6]  = '{2'b10, 0, 0, 3'b000, 10, 20, 3'b100,
                     2'b10, 32'd30, 0, 0, 0, 1};
        vecs[7]  = '{2'b11, 1, 1, 3'b000, 3, 4, 3'b011,
                     2'b01, 32'd2, 0, 0, 0, 0};
        vecs[8]  = '{2'b11, 1, 1, 3'b000, 3, 4, 3'b011,
                     2'b10, 32'd7, 0, 0, 0, 1};
        vecs[9]  = '{2'b11, 1, 1, 3'b000, 3, 4, 3'b011,
                     2'b01, 32'd2, 0, 0, 0, 0};
        vecs[10] = '{2'b11, 1, 1, 3'b000, 3, 4, 3'b011,
                     2'b10, 32'd7, 0, 0, 0, 1};
        vecs[11] = '{2'b01, 3, 5, 3'b001, 0, 0, 3'b000,
                     2'b01, 32'hFFFF_FFFE, 0, 0, 1, 0};

        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst result", rsp_result, 32'd0);
        chk("rst flags", 32'({rsp_carry, rsp_zero, rsp_negative}), 32'd0);
        chk("rst src", 32'(rsp_src), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ready", 32'(req_ready), 32'd0);

        for (int i = 0; i < 12; i++)
            run_vec(i);

        // Reset while the op is in EXEC: it must never be answered.
        req_valid = 2'b01;
        req_a     = {32'd0, 32'd9};
        req_b     = {32'd0, 32'd1};
        req_ctrl  = 6'b000_000;
        #1;
        chk("rmid accept", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        rst       = 1'b0;
        chk("rmid exec busy", 32'(busy), 32'd1);
        tick();
        chk("rmid busy", 32'(busy), 32'd0);
        chk("rmid rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rmid quiet%0d", k), 32'(rsp_valid), 32'd0);
        end

        // Reset asserted together with a handshake: reset wins.
        req_valid = 2'b10;
        rst       = 1'b0;
        tick();
        chk("rhs busy", 32'(busy), 32'd0);
        chk("rhs rsp_valid", 32'(rsp_valid), 32'd0);
        req_valid = 2'b00;
        rst       = 1'b1;
        tick();

        // Backpressure: response held for 10 cycles with all else frozen.
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        req_a     = {32'd5, 32'd0};
        req_b     = {32'd3, 32'd0};
        req_ctrl  = 6'b001_000;
        #1;
        chk("bp accept", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b11;
        tick();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp valid%0d", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp result%0d", k), rsp_result, 32'd2);
            chk($sformatf("bp src%0d", k), 32'(rsp_src), 32'd1);
            chk($sformatf("bp ready%0d", k), 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        chk("bp release valid", 32'(rsp_valid), 32'd0);
        chk("bp release busy", 32'(busy), 32'd0);

        // Idle cycles with no requests leave the pointer at 0.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("idle busy%0d", k), 32'(busy), 32'd0);
        end
        req_valid = 2'b11;
        #1;
        chk("idle ptr grant", 32'(req_ready), 32'd1);
        req_valid = 2'b00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
